// File: rtl/dishwash_pkg.sv
// Shared types and defaults for the dishwash water-valve arbiter.
// State encodings, default timing parameters and a one-hot helper.
package dishwash_pkg;

  localparam int NUM_WASHERS    = 2;
  localparam int DEF_GAP_CYCLES = 4;
  localparam int DEF_MAX_HOLD   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SERVE  = 2'd1,
    ARB_SWITCH = 2'd2
  } arb_state_t;

  function automatic logic [NUM_WASHERS-1:0] washer_onehot(input logic idx);
    return NUM_WASHERS'(1) << idx;
  endfunction

endpackage

// File: rtl/dishwash_water_arb_if.sv
// Washer-side bundle of the water arbiter: requests and tick in, grant, valve and gated ticks out.
// master = washer/controller side, slave = arbiter side.
interface dishwash_water_arb_if import dishwash_pkg::*; ();

  logic [NUM_WASHERS-1:0] req;
  logic                   hfminute_tick;
  logic [NUM_WASHERS-1:0] gnt;
  logic                   valve_open;
  logic [NUM_WASHERS-1:0] tick_out;
  logic                   busy;

  modport master (
    output req, hfminute_tick,
    input  gnt, valve_open, tick_out, busy
  );

  modport slave (
    input  req, hfminute_tick,
    output gnt, valve_open, tick_out, busy
  );

endinterface

// File: rtl/dishwash_water_arb.sv
// Purpose: share one hot-water valve between two washers with a closed flush gap and hold-time preemption.
// Latency: gnt/valve_open/tick_out registered, one clock after the sampled req/tick.
// Backpressure: a non-owning requester waits (and loses ticks) until granted; no request is dropped.
module dishwash_water_arb import dishwash_pkg::*; #(
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
  input logic                 clk,
  input logic                 rstb,
  dishwash_water_arb_if.slave bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  arb_state_t             state, state_nxt;
  logic                   own, own_nxt;
  logic                   target, target_nxt;
  logic                   last_srv, last_nxt;
  logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
  logic [GAP_W-1:0]       gap_cnt, gap_nxt;
  logic [NUM_WASHERS-1:0] gnt_q;
  logic                   valve_q;
  logic [NUM_WASHERS-1:0] tick_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= ARB_IDLE;
      own      <= 1'b0;
      target   <= 1'b0;
      last_srv <= 1'b1;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      own      <= own_nxt;
      target   <= target_nxt;
      last_srv <= last_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    own_nxt    = own;
    target_nxt = target;
    last_nxt   = last_srv;
    hold_nxt   = hold_cnt;
    gap_nxt    = gap_cnt;
    case (state)
      ARB_IDLE: begin
        if (|bus.req) begin
          state_nxt = ARB_SERVE;
          own_nxt   = (&bus.req) ? ~last_srv : bus.req[1];
          last_nxt  = own_nxt;
          hold_nxt  = '0;
        end
      end
      ARB_SERVE: begin
        // Release wins over an expiring hold in the same clock.
        if (!bus.req[own]) begin
          if (bus.req[~own]) begin
            state_nxt  = ARB_SWITCH;
            target_nxt = ~own;
            gap_nxt    = GAP_LOAD;
          end else begin
            state_nxt  = ARB_IDLE;
          end
        end else if (hold_cnt == HOLD_MAX && bus.req[~own]) begin
          state_nxt  = ARB_SWITCH;
          target_nxt = ~own;
          gap_nxt    = GAP_LOAD;
        end else if (bus.hfminute_tick && hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ARB_SWITCH: begin
        if (gap_cnt == '0) begin
          if (bus.req[target]) begin
            state_nxt = ARB_SERVE;
            own_nxt   = target;
            last_nxt  = target;
            hold_nxt  = '0;
          end else if (bus.req[~target]) begin
            state_nxt = ARB_SERVE;
            own_nxt   = ~target;
            last_nxt  = ~target;
            hold_nxt  = '0;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Outputs are registered from the next state so gnt and valve move together with it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      gnt_q   <= '0;
      valve_q <= 1'b0;
      tick_q  <= '0;
    end else begin
      gnt_q   <= (state_nxt == ARB_SERVE) ? washer_onehot(own_nxt) : '0;
      valve_q <= (state_nxt == ARB_SERVE);
      tick_q  <= {NUM_WASHERS{bus.hfminute_tick}} &
                 (~bus.req | (gnt_q & {NUM_WASHERS{valve_q}}));
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.valve_open = valve_q;
  assign bus.tick_out   = tick_q;
  assign bus.busy       = (state != ARB_IDLE);

endmodule

// File: tb/tb_dishwash_water_arb.sv
// Bench for dishwash_water_arb: fixed vector table, directed corner sequences, random traffic vs a reference model.
module tb_dishwash_water_arb;

  localparam int GAP  = 4;
  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dishwash_water_arb_if bus ();

  dishwash_water_arb #(.GAP_CYCLES(GAP), .MAX_HOLD(MAXH)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  // Reference model: who holds the valve (-1 none), remaining closed-gap clocks, ticks held.
  int         m_own, m_gap, m_tgt, m_hold, m_last;
  logic [1:0] m_tick;

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_gap = 0; m_tgt = 0; m_hold = 0; m_last = 1; m_tick = 2'b00;
  endtask

  task automatic model_grant(input int w);
    m_own = w; m_hold = 0; m_last = w;
  endtask

  task automatic model_step(input logic [1:0] r, input logic t);
    int oth;
    for (int i = 0; i < 2; i++) m_tick[i] = t && (!r[i] || m_own == i);
    if (m_own >= 0) begin
      oth = 1 - m_own;
      if (!r[m_own]) begin
        if (r[oth]) begin m_gap = GAP; m_tgt = oth; end
        m_own = -1;
      end else if (m_hold >= MAXH && r[oth]) begin
        m_gap = GAP; m_tgt = oth; m_own = -1;
      end else if (t) begin
        m_hold = (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
      end
    end else if (m_gap > 0) begin
      if (m_gap == 1) begin
        m_gap = 0;
        if (r[m_tgt]) model_grant(m_tgt);
        else if (r[1 - m_tgt]) model_grant(1 - m_tgt);
      end else begin
        m_gap--;
      end
    end else if (r != 2'b00) begin
      if (r == 2'b11) model_grant(1 - m_last);
      else model_grant(r[1] ? 1 : 0);
    end
  endtask

  function automatic logic [5:0] model_pack();
    logic [1:0] g;
    g = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
    return {g, m_own >= 0, m_tick, (m_own >= 0) || (m_gap > 0)};
  endfunction

  // Inputs applied just after a rising edge; outputs read 1 time unit after the next one.
  task automatic step(input logic [1:0] r, input logic t, output logic [5:0] got, output logic [5:0] mexp);
    bus.req = r;
    bus.hfminute_tick = t;
    model_step(r, t);
    mexp = model_pack();
    @(posedge clk);
    #1;
    got = {bus.gnt, bus.valve_open, bus.tick_out, bus.busy};
  endtask

  task automatic sm(input string name, input logic [1:0] r, input logic t, output logic [5:0] got);
    logic [5:0] mexp;
    step(r, t, got, mexp);
    chk(name, got, mexp);
  endtask

  task automatic do_reset();
    bus.req = 2'b00;
    bus.hfminute_tick = 1'b0;
    rstb = 1'b0;
    model_reset();
    @(negedge clk);
    #2 rstb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Invariants and closed-gap length, sampled on the falling edge.
  int sw_run = 0;
  always @(negedge clk) begin
    chk("gnt_onehot0_valve", 6'({$onehot0(bus.gnt), bus.valve_open == |bus.gnt}), 6'b000011);
    if (!rstb) begin
      sw_run = 0;
    end else if (bus.busy && bus.gnt == 2'b00) begin
      sw_run++;
    end else begin
      if (sw_run != 0) chk("switch_len", 6'(sw_run), 6'(GAP));
      sw_run = 0;
    end
  end

  typedef struct {
    bit         rst;
    logic [1:0] req;
    logic       tick;
    logic [1:0] gnt;
    logic       valve;
    logic [1:0] tout;
    logic       busy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [5:0] got, mexp;

    tbl[0]  = '{0, 2'b01, 0, 2'b01, 1, 2'b00, 1};
    tbl[1]  = '{0, 2'b01, 1, 2'b01, 1, 2'b11, 1};
    tbl[2]  = '{0, 2'b01, 0, 2'b01, 1, 2'b00, 1};
    tbl[3]  = '{0, 2'b00, 0, 2'b00, 0, 2'b00, 0};
    tbl[4]  = '{1, 2'b11, 0, 2'b01, 1, 2'b00, 1};
    tbl[5]  = '{0, 2'b10, 0, 2'b00, 0, 2'b00, 1};
    tbl[6]  = '{0, 2'b10, 0, 2'b00, 0, 2'b00, 1};
    tbl[7]  = '{0, 2'b10, 1, 2'b00, 0, 2'b01, 1};
    tbl[8]  = '{0, 2'b10, 0, 2'b00, 0, 2'b00, 1};
    tbl[9]  = '{0, 2'b10, 0, 2'b10, 1, 2'b00, 1};
    tbl[10] = '{0, 2'b10, 1, 2'b10, 1, 2'b11, 1};
    tbl[11] = '{0, 2'b00, 0, 2'b00, 0, 2'b00, 0};

    bus.req = 2'b00;
    bus.hfminute_tick = 1'b0;
    #3;
    chk("reset_state", {bus.gnt, bus.valve_open, bus.tick_out, bus.busy}, 6'b000000);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].req, tbl[i].tick, got, mexp);
      chk($sformatf("tbl[%0d]", i), got,
          {tbl[i].gnt, tbl[i].valve, tbl[i].tout, tbl[i].busy});
    end

    // Preemption of owner 0 after its MAX_HOLD-th tick.
    do_reset();
    sm("t3_grant", 2'b11, 0, got);
    chk("t3_first_owner", 6'(got[5:4]), 6'b000001);
    for (int i = 0; i < MAXH; i++) sm("t3_hold", 2'b11, 1, got);
    sm("t3_preempt", 2'b11, 0, got);
    chk("t3_gnt_dropped", 6'(got[5:4]), 6'b000000);
    sm("t3_gap_tick", 2'b11, 1, got);
    chk("t3_waiter_no_tick", 6'(got[2:1]), 6'b000000);
    for (int i = 0; i < GAP - 2; i++) sm("t3_gap", 2'b11, 0, got);
    sm("t3_switched", 2'b11, 0, got);
    chk("t3_new_owner", 6'(got[5:4]), 6'b000010);

    // Owner 1 alone through 10 ticks; saturated hold preempts as soon as washer 0 asks.
    do_reset();
    sm("t4_grant", 2'b10, 0, got);
    for (int i = 0; i < 10; i++) begin
      sm("t4_tick", 2'b10, 1, got);
      chk("t4_keeps", 6'(got[5:4]), 6'b000010);
      sm("t4_idle", 2'b10, 0, got);
    end
    sm("t4_other_req", 2'b11, 0, got);
    chk("t4_saturated_preempt", 6'(got[5:4]), 6'b000000);
    for (int i = 0; i < GAP; i++) sm("t4_gap", 2'b11, 0, got);
    chk("t4_to_w0", 6'(got[5:4]), 6'b000001);

    // Preempt toward washer 1 which then withdraws; second time both withdraw.
    do_reset();
    sm("t5_grant", 2'b11, 0, got);
    for (int i = 0; i < MAXH; i++) sm("t5_hold", 2'b11, 1, got);
    sm("t5_preempt", 2'b11, 0, got);
    for (int i = 0; i < GAP - 1; i++) sm("t5_gap", 2'b01, 0, got);
    sm("t5_back", 2'b01, 0, got);
    chk("t5_back_to_w0", 6'(got[5:4]), 6'b000001);
    sm("t5_req11", 2'b11, 0, got);
    for (int i = 0; i < MAXH; i++) sm("t5_hold2", 2'b11, 1, got);
    sm("t5_preempt2", 2'b11, 0, got);
    for (int i = 0; i < GAP - 1; i++) sm("t5_gap2", 2'b00, 0, got);
    sm("t5_idle", 2'b00, 0, got);
    chk("t5_idle_outputs", got, 6'b000000);

    // Asynchronous reset in the middle of SERVE.
    do_reset();
    sm("t6_grant", 2'b01, 0, got);
    sm("t6_serve", 2'b01, 1, got);
    #2 rstb = 1'b0;
    bus.req = 2'b00;
    bus.hfminute_tick = 1'b0;
    #1;
    chk("t6_async_close", {bus.gnt, bus.valve_open, bus.tick_out, bus.busy}, 6'b000000);
    model_reset();
    @(negedge clk);
    #2 rstb = 1'b1;
    @(posedge clk);
    #1;
    sm("t6_regrant", 2'b01, 0, got);
    chk("t6_regrant_w0", 6'(got[5:3]), 6'b000011);

    // Random traffic with slowly changing requests and occasional resets.
    do_reset();
    begin
      logic [1:0] r;
      r = 2'b00;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(599) == 0) do_reset();
        for (int b = 0; b < 2; b++)
          if ($urandom_range(11) == 0) r[b] = ~r[b];
        sm("rand", r, ($urandom_range(3) == 0), got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
